seg_display_mux: RTL and testbench
==================================

# seg_display_mux

Parametrised multi-channel seven-segment display controller, successor to the fixed two-register display path of the pipelined ARM top level. It selects one of `NUM_CH` processor-visible words, snapshots it once per refresh frame, and shows it on `NUM_DIGITS` multiplexed digits. Display is hexadecimal, or unsigned decimal via an iterative binary-to-BCD converter, with overflow indication and leading-zero blanking. It sits in `top` beside the `arm` core, fed from register taps, and drives the board's segment/anode pins.

## Interface
- `DATA_WIDTH`, 32, width of each channel word
- `NUM_CH`, 4, number of channels (≥2)
- `NUM_DIGITS`, 8, physical digits (≥2)
- `REFRESH_DIV`, 50000, clk cycles per digit slot (≥2)
- `BLANK_LZ`, 1, decimal mode blanks leading zeros (digit 0 always shown)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `ch_data`  in  NUM_CH*DATA_WIDTH  channel words, channel k at `[k*DATA_WIDTH +: DATA_WIDTH]`
- `page_next`  in  1  single-cycle pulse, advance selected channel
- `hex_mode`  in  1  1 = hex, 0 = unsigned decimal
- `freeze`  in  1  1 = suppress new snapshots
- `seg`  out  7  segments gfedcba, active-low
- `dp`  out  1  decimal point, active-low
- `an`  out  NUM_DIGITS  digit enables, active-low one-hot
- `cur_ch`  out  $clog2(NUM_CH)  selected channel
- `busy`  out  1  BCD conversion in progress

## Operation
- Reset values: `seg`=all 1, `dp`=1, `an`=all 1, `cur_ch`=0, `busy`=0; snapshot, BCD register, prescaler, digit index all 0; FSM IDLE.
- Prescaler counts 0..REFRESH_DIV-1; at terminal count, digit index increments, wrapping NUM_DIGITS-1→0. The wrap is the frame start.
- `page_next`: `cur_ch` increments, wrapping NUM_CH-1→0. Sets `snap_req`.
- Snapshot: at frame start with `freeze`=0, or when `snap_req` is set (any `freeze`), latch `ch_data[cur_ch]` and clear `snap_req`.
- Hex: digit i shows nibble i of the snapshot; nibbles beyond DATA_WIDTH show 0.
- Decimal: each snapshot starts the converter, an FSM with states IDLE→SHIFT (DATA_WIDTH cycles, add-3-then-shift)→COMMIT→IDLE.
  - COMMIT writes the NUM_DIGITS BCD register and the overflow flag.
  - Overflow is sticky: set if any 1 shifts out of the top BCD digit.
  - A snapshot during SHIFT/COMMIT sets `pending`; the FSM restarts from IDLE right after COMMIT, and only the newest value is converted.
  - The display shows the last committed value until the next COMMIT.
- Overflow display: all digits show dash (`seg`=7'b0111111).
- Leading-zero blanking (BLANK_LZ=1, decimal only): zero digits above the most significant nonzero digit show `seg`=all 1. Digit 0 is never blanked.
- `dp` is low only on digit index == `cur_ch` (if `cur_ch` < NUM_DIGITS).
- Reset asserted mid-conversion aborts it; all state returns to reset values.

## Timing
- Snapshot register updates on the clk edge at frame start, or one cycle after the `page_next` pulse.
- Decimal latency: snapshot at edge t → SHIFT from t+1 → COMMIT at t+DATA_WIDTH+1 → visible at t+DATA_WIDTH+2. `busy` is high from t+1 through the COMMIT cycle.
- Hex latency: digit value visible the cycle after the snapshot.
- `seg`/`an`/`dp` are registered and change together, one cycle after the digit index changes.
- Simultaneous `page_next` and frame start: one snapshot, of the new channel.

## Structure
- `seg_display_pkg`:
  - hex glyph constants 0–F (active-low)
  - `SEG_BLANK` and `SEG_DASH` constants
  - converter FSM state enum
- Sub-module `bin2bcd_seq` (parameters DATA_WIDTH, NUM_DIGITS):
  - inputs `start`, `bin`
  - outputs `busy`, `done` (COMMIT pulse), `bcd`, `ovf`
- Top file holds the prescaler, channel select, snapshot, glyph mux and output registers.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: hold `reset`=0 with random inputs → `seg`=7'h7F, `an`=8'hFF, `dp`=1, `cur_ch`=0, `busy`=0. Release → `an` walks FE,FD,…,7F, each held 4 cycles.
- Hex: ch0=32'h1234ABCD, `hex_mode`=1 → digits 0..7 show D,C,B,A,4,3,2,1.
- Decimal: ch0=32'd1234567, `hex_mode`=0 → `busy` high for 33 cycles, then digits show 01234567 with digit 7 blanked; with BLANK_LZ=0, digit 7 shows 0.
- Overflow: ch0=32'd100000000 decimal → all eight digits show dash. ch0=32'd99999999 → 99999999.
- Paging: 5 `page_next` pulses with NUM_CH=4 → `cur_ch` goes 1,2,3,0,1, and `dp` moves with it. A pulse with `freeze`=1 still snapshots the new channel; later ch_data changes are not shown.
- Mid-conversion: snapshot during SHIFT → one extra conversion, final display shows the newest value. Assert reset in SHIFT → `busy`=0 and outputs return to reset values immediately.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants and types for the multiplexed seven-segment display path.
package seg_display_pkg;

  // Active-low glyphs, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_SHIFT  = 2'd1,
    CONV_COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative add-3-then-shift binary to BCD converter, one bit per cycle,
// with a sticky overflow flag and a one-deep restart request.
module bin2bcd_seq
  import seg_display_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     bin,
  output logic                      busy,
  output logic                      done,
  output logic [4*NUM_DIGITS-1:0]   bcd,
  output logic                      ovf
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  conv_state_e            state_q, state_d;
  logic [BCD_W-1:0]       work_q, adj_c;
  logic [DATA_WIDTH-1:0]  bin_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_acc_q, pending_q, busy_q, done_q;
  logic                   go_c, last_c;

  // Per-digit add-3 correction ahead of the shift
  always_comb begin
    adj_c = work_q;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (work_q[4*d +: 4] > 4'd4) adj_c[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    go_c    = 1'b0;
    last_c  = (cnt_q == CNT_W'(DATA_WIDTH - 1));
    case (state_q)
      CONV_IDLE: begin
        if (start || pending_q) begin
          state_d = CONV_SHIFT;
          go_c    = 1'b1;
        end
      end
      CONV_SHIFT:  if (last_c) state_d = CONV_COMMIT;
      CONV_COMMIT: state_d = CONV_IDLE;
      default:     state_d = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= CONV_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_q    <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_d != CONV_IDLE);
      done_q <= (state_d == CONV_COMMIT);
      if (go_c) begin
        work_q    <= '0;
        bin_q     <= bin;
        cnt_q     <= '0;
        ovf_acc_q <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        // A newer snapshot arriving mid-conversion is picked up after COMMIT
        if (state_q != CONV_IDLE && start) pending_q <= 1'b1;
        if (state_q == CONV_SHIFT) begin
          work_q    <= {adj_c[BCD_W-2:0], bin_q[DATA_WIDTH-1]};
          bin_q     <= bin_q << 1;
          cnt_q     <= cnt_q + CNT_W'(1);
          ovf_acc_q <= ovf_acc_q | adj_c[BCD_W-1];
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = work_q;
  assign ovf  = ovf_acc_q;

endmodule

// File: rtl/seg_display_mux.sv
// Multi-channel seven-segment controller: channel paging, per-frame snapshot,
// hex or decimal rendering and registered digit multiplexing.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
  input  logic                           page_next,
  input  logic                           hex_mode,
  input  logic                           freeze,
  output logic [6:0]                     seg,
  output logic                           dp,
  output logic [NUM_DIGITS-1:0]          an,
  output logic [$clog2(NUM_CH)-1:0]      cur_ch,
  output logic                           busy
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned DIG_W = $clog2(NUM_DIGITS);
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned HEX_W = (DATA_WIDTH > BCD_W) ? DATA_WIDTH : BCD_W;

  logic [PRE_W-1:0]       presc_q;
  logic [DIG_W-1:0]       digit_q;
  logic [CH_W-1:0]        cur_ch_q;
  logic                   snap_req_q, snap_fire_q;
  logic [DATA_WIDTH-1:0]  snap_q;
  logic [BCD_W-1:0]       disp_bcd_q;
  logic                   disp_ovf_q;
  logic [6:0]             seg_q;
  logic                   dp_q;
  logic [NUM_DIGITS-1:0]  an_q;

  logic                   tick_c, frame_start_c, take_snap_c;
  logic [BCD_W-1:0]       conv_bcd_c;
  logic                   conv_ovf_c, conv_busy_c, conv_done_c;
  logic [HEX_W-1:0]       snap_pad_c;
  logic [3:0]             nib_c, bcd_dig_c;
  logic                   upper_zero_c;
  logic [6:0]             glyph_c;

  assign tick_c        = (presc_q == PRE_W'(REFRESH_DIV - 1));
  assign frame_start_c = tick_c && (digit_q == DIG_W'(NUM_DIGITS - 1));
  // A page pulse on the frame-start edge defers to the new channel's snapshot
  assign take_snap_c   = snap_req_q || (frame_start_c && !freeze && !page_next);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      digit_q <= '0;
    end else if (tick_c) begin
      presc_q <= '0;
      digit_q <= (digit_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_ch_q    <= '0;
      snap_req_q  <= 1'b0;
      snap_fire_q <= 1'b0;
      snap_q      <= '0;
    end else begin
      if (page_next) cur_ch_q <= (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);
      snap_req_q  <= page_next | (snap_req_q & ~take_snap_c);
      snap_fire_q <= take_snap_c;
      if (take_snap_c) snap_q <= ch_data[32'(cur_ch_q) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  bin2bcd_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (snap_fire_q),
    .bin   (snap_q),
    .busy  (conv_busy_c),
    .done  (conv_done_c),
    .bcd   (conv_bcd_c),
    .ovf   (conv_ovf_c)
  );

  // Decimal display holds the last committed conversion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
    end else if (conv_done_c) begin
      disp_bcd_q <= conv_bcd_c;
      disp_ovf_q <= conv_ovf_c;
    end
  end

  always_comb begin
    snap_pad_c   = HEX_W'(snap_q);
    nib_c        = snap_pad_c[4*32'(digit_q) +: 4];
    bcd_dig_c    = disp_bcd_q[4*32'(digit_q) +: 4];
    upper_zero_c = ((disp_bcd_q >> (4*32'(digit_q))) == '0);
    glyph_c      = hex_glyph(bcd_dig_c);
    if (hex_mode)                                             glyph_c = hex_glyph(nib_c);
    else if (disp_ovf_q)                                      glyph_c = SEG_DASH;
    else if ((BLANK_LZ != 0) && (digit_q != '0) && upper_zero_c) glyph_c = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      seg_q <= glyph_c;
      dp_q  <= (32'(digit_q) != 32'(cur_ch_q));
      an_q  <= ~(NUM_DIGITS'(1) << digit_q);
    end
  end

  assign seg    = seg_q;
  assign dp     = dp_q;
  assign an     = an_q;
  assign cur_ch = cur_ch_q;
  assign busy   = conv_busy_c;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with a fast refresh divider.
module tb_seg_display_mux;

  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 4;
  localparam int unsigned ND  = 8;
  localparam int unsigned DIV = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [127:0]  ch_data;
  logic          page_next, hex_mode, freeze;
  logic [6:0]    seg, seg0;
  logic          dp, dp0, busy, busy0;
  logic [7:0]    an, an0;
  logic [1:0]    cur_ch, cur_ch0;

  int total = 0;
  int bad   = 0;
  int cur_exp = 0;

  always #5 clk = ~clk;

  seg_display_mux #(.DATA_WIDTH(DW), .NUM_CH(NCH), .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .page_next(page_next), .hex_mode(hex_mode),
    .freeze(freeze), .seg(seg), .dp(dp), .an(an), .cur_ch(cur_ch), .busy(busy));

  seg_display_mux #(.DATA_WIDTH(DW), .NUM_CH(NCH), .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_LZ(0)) dut0 (
    .clk(clk), .reset(reset), .ch_data(ch_data), .page_next(page_next), .hex_mode(hex_mode),
    .freeze(freeze), .seg(seg0), .dp(dp0), .an(an0), .cur_ch(cur_ch0), .busy(busy0));

  typedef struct {
    logic [31:0] val;
    logic        hex;
    logic [31:0] nib;
    logic [7:0]  blank;
    logic        dash;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [55:0] exp_frame(input logic [31:0] nib, input logic [7:0] blank,
                                            input logic dash, input bit use_blank);
    logic [55:0] r;
    for (int d = 0; d < 8; d++) begin
      if (dash)                       r[7*d +: 7] = 7'b0111111;
      else if (use_blank && blank[d]) r[7*d +: 7] = 7'b1111111;
      else                            r[7*d +: 7] = ref_glyph(nib[4*d +: 4]);
    end
    return r;
  endfunction

  task automatic pulse_page();
    @(negedge clk); page_next = 1'b1;
    @(negedge clk); page_next = 1'b0;
    cur_exp = (cur_exp + 1) % NCH;
  endtask

  // Scan one refresh frame, recording each digit's glyph and dp
  task automatic capture(output logic [55:0] s, output logic [55:0] s0, output logic [7:0] dpv);
    logic [7:0] seen;
    logic [7:0] sel;
    seen = '0; s = '1; s0 = '1; dpv = '1;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      for (int d = 0; d < 8; d++) begin
        sel = ~(8'd1 << d);
        if (an == sel) begin
          s[7*d +: 7]  = seg;
          s0[7*d +: 7] = seg0;
          dpv[d]       = dp;
          seen[d]      = 1'b1;
        end
      end
    end
    chk("frame_seen", 64'(seen), 64'hFF);
  endtask

  task automatic wait_conv(output int lat, output int width);
    lat = 0;
    while (!busy && lat < 8) begin @(negedge clk); lat++; end
    width = 0;
    while (busy && width < 60) begin width++; @(negedge clk); end
  endtask

  task automatic check_frame(input string name, input logic [31:0] nib, input logic [7:0] blank,
                             input logic dash);
    logic [55:0] s, s0;
    logic [7:0]  dpv, dexp;
    capture(s, s0, dpv);
    dexp = ~(8'd1 << cur_exp);
    chk({name, "_seg"},  64'(s),   64'(exp_frame(nib, blank, dash, 1'b1)));
    chk({name, "_seg0"}, 64'(s0),  64'(exp_frame(nib, blank, dash, 1'b0)));
    chk({name, "_dp"},   64'(dpv), 64'(dexp));
  endtask

  initial begin
    int lat, width, rises;
    logic prev;
    logic [7:0] an_exp;
    int pexp[5];

    vecs[0] = '{32'h1234ABCD,   1'b1, 32'h1234ABCD, 8'h00, 1'b0};
    vecs[1] = '{32'd1234567,    1'b0, 32'h01234567, 8'h80, 1'b0};
    vecs[2] = '{32'd100000000,  1'b0, 32'h00000000, 8'h00, 1'b1};
    vecs[3] = '{32'd99999999,   1'b0, 32'h99999999, 8'h00, 1'b0};
    vecs[4] = '{32'd0,          1'b0, 32'h00000000, 8'hFE, 1'b0};
    vecs[5] = '{32'h000000F0,   1'b1, 32'h000000F0, 8'h00, 1'b0};
    vecs[6] = '{32'd1000,       1'b0, 32'h00001000, 8'hF0, 1'b0};
    vecs[7] = '{32'hFFFFFFFF,   1'b1, 32'hFFFFFFFF, 8'h00, 1'b0};
    pexp = '{1, 2, 3, 0, 1};

    // Reset held with random inputs
    reset = 1'b0;
    ch_data = {$urandom, $urandom, $urandom, $urandom};
    page_next = 1'($urandom); hex_mode = 1'($urandom); freeze = 1'($urandom);
    repeat (3) begin
      @(negedge clk);
      ch_data = {$urandom, $urandom, $urandom, $urandom};
      page_next = 1'($urandom);
    end
    chk("rst_seg",   64'(seg),    64'h7F);
    chk("rst_seg0",  64'(seg0),   64'h7F);
    chk("rst_an",    64'(an),     64'hFF);
    chk("rst_dp",    64'(dp),     64'h1);
    chk("rst_cur",   64'(cur_ch), 64'h0);
    chk("rst_busy",  64'(busy),   64'h0);
    chk("rst_busy0", 64'(busy0),  64'h0);

    page_next = 1'b0; freeze = 1'b1; hex_mode = 1'b1;
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      an_exp = ~(8'd1 << (k / 4));
      chk("an_walk", 64'(an), 64'(an_exp));
    end

    // Table: one snapshot per row via page_next with freeze held
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      ch_data  = {4{vecs[r].val}};
      hex_mode = vecs[r].hex;
      pulse_page();
      wait_conv(lat, width);
      chk("busy_lat",   64'(lat),   64'd2);
      chk("busy_width", 64'(width), 64'd33);
      chk("row_cur",    64'(cur_ch), 64'(cur_exp));
      repeat (2) @(negedge clk);
      check_frame("row", vecs[r].nib, vecs[r].blank, vecs[r].dash);
    end

    // Paging and freeze
    ch_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    hex_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse_page();
      chk("page_cur", 64'(cur_ch), 64'(pexp[i]));
    end
    repeat (4) @(negedge clk);
    ch_data[63:32] = 32'h55555555;
    repeat (80) @(negedge clk);
    check_frame("frozen", 32'h22222222, 8'h00, 1'b0);
    freeze = 1'b0;
    repeat (80) @(negedge clk);
    check_frame("unfrozen", 32'h55555555, 8'h00, 1'b0);

    // Snapshot arriving during SHIFT
    freeze = 1'b1; hex_mode = 1'b0;
    repeat (80) @(negedge clk);
    ch_data = {4{32'd1234}};
    pulse_page();
    repeat (10) @(negedge clk);
    chk("busy_in_shift", 64'(busy), 64'h1);
    ch_data = {4{32'd87654321}};
    pulse_page();
    rises = 0; prev = busy;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (busy && !prev) rises++;
      prev = busy;
    end
    chk("restart_count", 64'(rises), 64'd1);
    chk("idle_after",    64'(busy),  64'h0);
    check_frame("newest", 32'h87654321, 8'h00, 1'b0);

    // Reset asserted in SHIFT
    pulse_page();
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy),   64'h0);
    chk("abort_seg",  64'(seg),    64'h7F);
    chk("abort_an",   64'(an),     64'hFF);
    chk("abort_dp",   64'(dp),     64'h1);
    chk("abort_cur",  64'(cur_ch), 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
